// File: rtl/apb2axi_completion_queue.sv
// Completion queue: per-TAG response accumulators feeding a small completion FIFO.
// Optional protocol checking is enabled by defining APB2AXI_CQ_PROTO_CHECK_EN.
package apb2axi_pkg;
  localparam int TAG_NUM    = 8;
  localparam int TAG_W      = $clog2(TAG_NUM);
  localparam int CPL_BEAT_W = 9;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [1:0]            resp;
    logic [CPL_BEAT_W-1:0] num_beats;
    logic                  error;
    logic [CPL_BEAT_W-1:0] err_beat_idx;
  } completion_entry_t;
endpackage

module apb2axi_completion_queue
  import apb2axi_pkg::*;
#(
  parameter int CQ_DEPTH = 4,
  parameter int BEAT_W   = 9
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          rsp_cq_beat_vld,
  input  logic [TAG_W-1:0]              rsp_cq_beat_tag,
  input  logic [1:0]                    rsp_cq_beat_resp,
  input  logic                          rsp_cq_beat_last,
  output logic                          rsp_cq_beat_rdy,
  output logic                          cq_dir_cpl_vld,
  output completion_entry_t             cq_dir_cpl_entry,
  input  logic                          cq_dir_cpl_rdy,
  output logic [$clog2(CQ_DEPTH+1)-1:0] cq_occupancy,
  output logic                          cq_proto_err
);
  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = $clog2(CQ_DEPTH + 1);

  logic [BEAT_W-1:0]  cnt_q        [TAG_NUM];
  logic [TAG_NUM-1:0] err_q;
  logic [1:0]         first_resp_q [TAG_NUM];
  logic [BEAT_W-1:0]  err_idx_q    [TAG_NUM];

  completion_entry_t  storage_q [CQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               beat_acc, push, pop, cnt_sat, cur_err;
  logic [BEAT_W-1:0]  cur_cnt, cur_err_idx;
  logic [1:0]         cur_first_resp;
  completion_entry_t  new_entry;

  // Backpressure looks only at the registered count, never at the pop in flight.
  assign rsp_cq_beat_rdy  = (count_q != CNT_W'(CQ_DEPTH));
  assign beat_acc         = rsp_cq_beat_vld && rsp_cq_beat_rdy;
  assign push             = beat_acc && rsp_cq_beat_last;
  assign cq_dir_cpl_vld   = (count_q != '0);
  assign pop              = cq_dir_cpl_vld && cq_dir_cpl_rdy;
  assign cq_dir_cpl_entry = storage_q[rd_ptr_q];
  assign cq_occupancy     = count_q;

  assign cur_cnt        = cnt_q[rsp_cq_beat_tag];
  assign cur_err        = err_q[rsp_cq_beat_tag];
  assign cur_first_resp = first_resp_q[rsp_cq_beat_tag];
  assign cur_err_idx    = err_idx_q[rsp_cq_beat_tag];

`ifdef APB2AXI_CQ_PROTO_CHECK_EN
  assign cnt_sat = (cur_cnt == BEAT_W'(256));
`else
  assign cnt_sat = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    new_entry           = '0;
    new_entry.tag       = rsp_cq_beat_tag;
    new_entry.num_beats = CPL_BEAT_W'(cur_cnt + BEAT_W'(1));
    new_entry.error     = cur_err | rsp_cq_beat_resp[1];
    if (cur_err) begin
      new_entry.resp         = cur_first_resp;
      new_entry.err_beat_idx = CPL_BEAT_W'(cur_err_idx);
    end else begin
      new_entry.resp         = rsp_cq_beat_resp;
      new_entry.err_beat_idx = rsp_cq_beat_resp[1] ? CPL_BEAT_W'(cur_cnt) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        cnt_q[i]        <= '0;
        first_resp_q[i] <= '0;
        err_idx_q[i]    <= '0;
      end
      err_q <= '0;
    end else if (beat_acc) begin
      if (rsp_cq_beat_last) begin
        cnt_q[rsp_cq_beat_tag]        <= '0;
        err_q[rsp_cq_beat_tag]        <= 1'b0;
        first_resp_q[rsp_cq_beat_tag] <= '0;
        err_idx_q[rsp_cq_beat_tag]    <= '0;
      end else begin
        if (!cnt_sat) cnt_q[rsp_cq_beat_tag] <= cur_cnt + BEAT_W'(1);
        if (rsp_cq_beat_resp[1] && !cur_err) begin
          err_q[rsp_cq_beat_tag]        <= 1'b1;
          first_resp_q[rsp_cq_beat_tag] <= rsp_cq_beat_resp;
          err_idx_q[rsp_cq_beat_tag]    <= cur_cnt;
        end
      end
    end
  end

  // NOTE: storage is reset because the head entry is visible on the output and must read '0 after reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < CQ_DEPTH; i++) storage_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        storage_q[wr_ptr_q] <= new_entry;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef APB2AXI_CQ_PROTO_CHECK_EN
  logic tag_pending, proto_err_q;

  // A TAG must not be reused while its completion still sits in the FIFO.
  always_comb begin
    tag_pending = 1'b0;
    for (int i = 0; i < CQ_DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (storage_q[rd_ptr_q + PTR_W'(i)].tag == rsp_cq_beat_tag))
        tag_pending = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) proto_err_q <= 1'b0;
    else if (beat_acc && ((!rsp_cq_beat_last && cnt_sat) || tag_pending))
      proto_err_q <= 1'b1;
  end

  assign cq_proto_err = proto_err_q;
`else
  assign cq_proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_apb2axi_completion_queue.sv
// Self-checking bench for apb2axi_completion_queue: table vectors, corner sequences, random vs model.
module tb_apb2axi_completion_queue;
  import apb2axi_pkg::*;

  logic              pclk, presetn;
  logic              beat_vld, beat_last, beat_rdy, cpl_vld, cpl_rdy, proto_err;
  logic [TAG_W-1:0]  beat_tag;
  logic [1:0]        beat_resp;
  completion_entry_t cpl_entry;
  logic [2:0]        occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  completion_entry_t sb [$];
  typedef logic [1:0] resp_q_t [$];
  resp_q_t hist [TAG_NUM];
  bit model_en = 0;

  apb2axi_completion_queue #(.CQ_DEPTH(4), .BEAT_W(9)) dut (
    .pclk(pclk), .presetn(presetn),
    .rsp_cq_beat_vld(beat_vld), .rsp_cq_beat_tag(beat_tag),
    .rsp_cq_beat_resp(beat_resp), .rsp_cq_beat_last(beat_last),
    .rsp_cq_beat_rdy(beat_rdy),
    .cq_dir_cpl_vld(cpl_vld), .cq_dir_cpl_entry(cpl_entry),
    .cq_dir_cpl_rdy(cpl_rdy), .cq_occupancy(occupancy),
    .cq_proto_err(proto_err)
  );

  initial pclk = 0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic completion_entry_t mk(input int tag, input logic [1:0] resp,
                                           input int nb, input logic err, input int idx);
    completion_entry_t e;
    e.tag          = TAG_W'(tag);
    e.resp         = resp;
    e.num_beats    = CPL_BEAT_W'(nb);
    e.error        = err;
    e.err_beat_idx = CPL_BEAT_W'(idx);
    return e;
  endfunction

  // Scoreboard: every completion handed to the directory must match the expected queue head.
  always @(negedge pclk) begin
    if (presetn && cpl_vld && cpl_rdy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_cpl: got %0h expected none", cpl_entry);
      end else begin
        check("cpl_entry", 64'(cpl_entry), 64'(sb.pop_front()));
      end
    end
  end

  // Reference model: a completion summarises the full list of responses seen for its TAG.
  task automatic model_beat(input int tag, input logic [1:0] resp, input logic last);
    completion_entry_t e;
    logic [1:0] r;
    hist[tag].push_back(resp);
    if (last) begin
      e = mk(tag, resp, hist[tag].size(), 1'b0, 0);
      for (int k = 0; k < hist[tag].size(); k++) begin
        r = hist[tag][k];
        if (r[1] && !e.error) begin
          e.error        = 1'b1;
          e.resp         = r;
          e.err_beat_idx = CPL_BEAT_W'(k);
        end
      end
      sb.push_back(e);
      hist[tag].delete();
    end
  endtask

  task automatic send_beat(input int tag, input logic [1:0] resp, input logic last);
    int waited = 0;
    beat_vld  = 1'b1;
    beat_tag  = TAG_W'(tag);
    beat_resp = resp;
    beat_last = last;
    while (!beat_rdy) begin
      @(posedge pclk); #1;
      waited++;
      if (waited > 5) cpl_rdy = 1'b1;
      if (waited > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_timeout: got rdy=0 expected rdy=1 tag %0d", tag);
        beat_vld = 1'b0;
        return;
      end
    end
    @(posedge pclk); #1;
    beat_vld = 1'b0;
    if (model_en) model_beat(tag, resp, last);
  endtask

  task automatic drain();
    int waited = 0;
    cpl_rdy = 1'b1;
    while ((cpl_vld || sb.size() != 0) && waited < 100) begin
      @(posedge pclk); #1;
      waited++;
    end
    check("drain_vld", 64'(cpl_vld), 64'(0));
    check("drain_sb_left", 64'(sb.size()), 64'(0));
  endtask

  typedef struct {
    int         tag;
    int         nbeats;
    int         e1_beat;
    logic [1:0] e1_resp;
    int         e2_beat;
    logic [1:0] e2_resp;
    logic [1:0] exp_resp;
    logic       exp_err;
    int         exp_idx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [1:0] r;
    int nopen;

    vecs[0] = '{2, 4, -1, 2'd0, -1, 2'd0, 2'd0, 1'b0, 0};
    vecs[1] = '{1, 8,  3, 2'd2,  5, 2'd3, 2'd2, 1'b1, 3};
    vecs[2] = '{5, 1,  0, 2'd3, -1, 2'd0, 2'd3, 1'b1, 0};
    vecs[3] = '{7, 3,  2, 2'd2, -1, 2'd0, 2'd2, 1'b1, 2};
    vecs[4] = '{4, 2,  0, 2'd1, -1, 2'd0, 2'd0, 1'b0, 0};
    vecs[5] = '{6, 5,  1, 2'd3,  4, 2'd2, 2'd3, 1'b1, 1};

    presetn = 0; beat_vld = 0; beat_tag = '0; beat_resp = '0; beat_last = 0; cpl_rdy = 1;
    #1;
    check("rst_beat_rdy", 64'(beat_rdy), 64'(1));
    check("rst_cpl_vld", 64'(cpl_vld), 64'(0));
    check("rst_cpl_entry", 64'(cpl_entry), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    #21 presetn = 1;
    @(posedge pclk); #1;

    // Single-TAG bursts: entry one cycle after the last beat, visible for exactly one cycle.
    foreach (vecs[v]) begin
      sb.push_back(mk(vecs[v].tag, vecs[v].exp_resp, vecs[v].nbeats, vecs[v].exp_err, vecs[v].exp_idx));
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        r = (b == vecs[v].e1_beat) ? vecs[v].e1_resp :
            (b == vecs[v].e2_beat) ? vecs[v].e2_resp : 2'd0;
        send_beat(vecs[v].tag, r, b == vecs[v].nbeats - 1);
      end
      check("vec_vld_after_last", 64'(cpl_vld), 64'(1));
      @(posedge pclk); #1;
      check("vec_vld_one_cycle", 64'(cpl_vld), 64'(0));
    end

    // Interleaved TAGs 0 and 3; TAG 3 completes first.
    sb.push_back(mk(3, 2'd0, 2, 1'b0, 0));
    sb.push_back(mk(0, 2'd0, 4, 1'b0, 0));
    send_beat(0, 2'd0, 1'b0);
    send_beat(3, 2'd0, 1'b0);
    send_beat(0, 2'd0, 1'b0);
    send_beat(3, 2'd0, 1'b1);
    send_beat(0, 2'd0, 1'b0);
    send_beat(0, 2'd0, 1'b1);
    drain();

    // Backpressure: directory stalled, FIFO fills, fifth beat held off.
    cpl_rdy = 1'b0;
    for (int t = 0; t < 5; t++) sb.push_back(mk(t, 2'd0, 1, 1'b0, 0));
    for (int t = 0; t < 4; t++) send_beat(t, 2'd0, 1'b1);
    check("full_occupancy", 64'(occupancy), 64'(4));
    check("full_rdy_low", 64'(beat_rdy), 64'(0));
    beat_vld = 1'b1; beat_tag = TAG_W'(4); beat_resp = 2'd0; beat_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk); #1;
      check("stall_rdy", 64'(beat_rdy), 64'(0));
      check("stall_occupancy", 64'(occupancy), 64'(4));
      check("stall_head_tag", 64'(cpl_entry.tag), 64'(0));
    end
    cpl_rdy = 1'b1;
    @(posedge pclk); #1;
    check("release_rdy", 64'(beat_rdy), 64'(1));
    check("release_occupancy", 64'(occupancy), 64'(3));
    @(posedge pclk); #1;
    beat_vld = 1'b0;
    drain();

    // Random interleaved traffic against the model.
    model_en = 1;
    for (int n = 0; n < 300; n++) begin
      cpl_rdy = ($urandom_range(0, 3) != 0);
      send_beat($urandom_range(0, TAG_NUM - 1), 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end
    nopen = 0;
    for (int t = 0; t < TAG_NUM; t++) begin
      if (hist[t].size() != 0) begin
        nopen++;
        send_beat(t, 2'($urandom_range(0, 3)), 1'b1);
      end
    end
    drain();
    model_en = 0;

    // Beat counter limit on TAG 0.
    for (int n = 0; n < 257; n++) send_beat(0, 2'd0, 1'b0);
`ifdef APB2AXI_CQ_PROTO_CHECK_EN
    check("proto_err_set", 64'(proto_err), 64'(1));
    repeat (3) @(posedge pclk);
    #1 check("proto_err_sticky", 64'(proto_err), 64'(1));
    sb.push_back(mk(0, 2'd0, 257, 1'b0, 0));
`else
    check("proto_err_off", 64'(proto_err), 64'(0));
    repeat (3) @(posedge pclk);
    #1 check("proto_err_off_hold", 64'(proto_err), 64'(0));
    sb.push_back(mk(0, 2'd0, 258, 1'b0, 0));
`endif
    send_beat(0, 2'd0, 1'b1);
    drain();

    // Reset mid-burst with a completion still queued.
    cpl_rdy = 1'b0;
    send_beat(5, 2'd0, 1'b1);
    send_beat(1, 2'd0, 1'b0);
    send_beat(1, 2'd0, 1'b0);
    check("pre_reset_vld", 64'(cpl_vld), 64'(1));
    #2 presetn = 1'b0;
    #1;
    check("midrst_beat_rdy", 64'(beat_rdy), 64'(1));
    check("midrst_cpl_vld", 64'(cpl_vld), 64'(0));
    check("midrst_cpl_entry", 64'(cpl_entry), 64'(0));
    check("midrst_occupancy", 64'(occupancy), 64'(0));
    check("midrst_proto_err", 64'(proto_err), 64'(0));
    sb.delete();
    @(negedge pclk);
    presetn = 1'b1;
    cpl_rdy = 1'b1;
    @(posedge pclk); #1;
    sb.push_back(mk(1, 2'd0, 1, 1'b0, 0));
    send_beat(1, 2'd0, 1'b1);
    check("post_rst_vld", 64'(cpl_vld), 64'(1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
